// File: rtl/mem_pkg.sv
// Shared widths and enums for the icache/dcache memory arbiter.
package mem_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;
endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refills and dcache
// accesses, with a per-transaction BUSY-cycle timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err,
  output state_t            state_dbg
);

  // Handshake: i_req/d_req are levels held until the matching one-cycle *_done
  // pulse; mem_req is held for the whole BUSY phase and mem_ready is a one-cycle
  // completion that is only honoured while BUSY.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t      state;
  state_t      state_next;
  req_id_t     owner;
  req_id_t     last_id;
  req_id_t     grant_id;
  logic [CNT_W-1:0] busy_cnt;
  logic        any_req;
  logic        timeout_hit;

  assign any_req     = i_req | d_req;
  assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT - 1));
  assign state_dbg   = state;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = REQ_D;
    if (i_req && d_req) begin
      grant_id = (last_id == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req) begin
      grant_id = REQ_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state == BUSY);
    i_done  = (state == DONE) && (owner == REQ_I);
    d_done  = (state == DONE) && (owner == REQ_D);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      owner       <= REQ_I;
      last_id     <= REQ_I;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= grant_id;
            last_id  <= grant_id;
            busy_cnt <= '0;
            if (grant_id == REQ_D) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          busy_cnt <= busy_cnt + 1'b1;
          // mem_ready wins over a timeout landing in the same cycle; writes never touch rdata.
          if (mem_ready) begin
            if (!mem_we) begin
              if (owner == REQ_D) d_rdata <= mem_rdata;
              else                i_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            if (!mem_we) begin
              if (owner == REQ_D) d_rdata <= '0;
              else                i_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for single transactions plus
// hand sequences for arbitration, timeout, and reset corners.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        i_req, d_req, d_we, mem_ready;
  logic [19:0] i_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;

  logic        i_done, d_done, mem_req, mem_we, timeout_err;
  logic [31:0] i_rdata, d_rdata, mem_wdata;
  logic [19:0] mem_addr;
  state_t      state_dbg;

  logic        t_i_done, t_d_done, t_mem_req, t_mem_we, t_timeout_err;
  logic [31:0] t_i_rdata, t_d_rdata, t_mem_wdata;
  logic [19:0] t_mem_addr;
  state_t      t_state_dbg;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_to (
    .CLK(CLK), .RST_N(RST_N),
    .i_req(i_req), .i_addr(i_addr), .i_done(t_i_done), .i_rdata(t_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(t_d_done), .d_rdata(t_d_rdata),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(t_timeout_err), .state_dbg(t_state_dbg)
  );

  // clock
  always #5 CLK = ~CLK;

  typedef struct {
    logic        i_req;
    logic [19:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [19:0] d_addr;
    logic [31:0] d_wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        x_mreq;
    logic        x_mwe;
    logic [19:0] x_maddr;
    logic [31:0] x_mwdata;
    logic        x_idone;
    logic        x_ddone;
    logic [31:0] x_irdata;
    logic [31:0] x_drdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ir, logic [19:0] ia, logic dr, logic dw, logic [19:0] da,
                              logic [31:0] dwd, logic rdy, logic [31:0] rd,
                              logic xmr, logic xmw, logic [19:0] xma, logic [31:0] xmwd,
                              logic xid, logic xdd, logic [31:0] xir, logic [31:0] xdr);
    vec_t v;
    v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.ready = rdy; v.rdata = rd;
    v.x_mreq = xmr; v.x_mwe = xmw; v.x_maddr = xma; v.x_mwdata = xmwd;
    v.x_idone = xid; v.x_ddone = xdd; v.x_irdata = xir; v.x_drdata = xdr;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  // scoreboard: the two done pulses of one arbiter must never coincide
  always @(negedge CLK) begin
    checks++;
    if ((i_done && d_done) || (t_i_done && t_d_done)) begin
      errors++;
      $display("FAIL done_overlap: got i=%b d=%b ti=%b td=%b expected no overlap",
               i_done, d_done, t_i_done, t_d_done);
    end
  end

  logic        exp_d;
  logic [31:0] val;

  initial begin
    do_reset();
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst i_done", i_done, 0);
    check("rst d_done", d_done, 0);
    check("rst i_rdata", i_rdata, 0);
    check("rst d_rdata", d_rdata, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst state", 32'(state_dbg), 32'(IDLE));

    // icache refill, dcache read, idle mem_ready, dcache write
    vecs.push_back(mk(1, 20'h00104, 0, 0, 20'h0, 32'h0, 0, 32'h0,          1, 0, 20'h00104, 32'h0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 20'h00104, 0, 0, 20'h0, 32'h0, 0, 32'h0,          1, 0, 20'h00104, 32'h0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 20'h00104, 0, 0, 20'h0, 32'h0, 0, 32'h0,          1, 0, 20'h00104, 32'h0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 20'h00104, 0, 0, 20'h0, 32'h0, 1, 32'h00B70113,   0, 0, 20'h00104, 32'h0, 1, 0, 32'h00B70113, 32'h0));
    vecs.push_back(mk(0, 20'h00104, 0, 0, 20'h0, 32'h0, 0, 32'h0,          0, 0, 20'h00104, 32'h0, 0, 0, 32'h00B70113, 32'h0));
    vecs.push_back(mk(0, 20'h00104, 0, 0, 20'h0, 32'h0, 1, 32'hFFFFFFFF,   0, 0, 20'h00104, 32'h0, 0, 0, 32'h00B70113, 32'h0));
    vecs.push_back(mk(0, 20'h0, 1, 0, 20'h00300, 32'h0, 0, 32'h0,          1, 0, 20'h00300, 32'h0, 0, 0, 32'h00B70113, 32'h0));
    vecs.push_back(mk(0, 20'h0, 1, 0, 20'h00300, 32'h0, 1, 32'hCAFEF00D,   0, 0, 20'h00300, 32'h0, 0, 1, 32'h00B70113, 32'hCAFEF00D));
    vecs.push_back(mk(0, 20'h0, 0, 0, 20'h00300, 32'h0, 0, 32'h0,          0, 0, 20'h00300, 32'h0, 0, 0, 32'h00B70113, 32'hCAFEF00D));
    vecs.push_back(mk(0, 20'h0, 1, 1, 20'h00200, 32'hDEADBEEF, 0, 32'h0,   1, 1, 20'h00200, 32'hDEADBEEF, 0, 0, 32'h00B70113, 32'hCAFEF00D));
    vecs.push_back(mk(0, 20'h0, 1, 1, 20'h00200, 32'hDEADBEEF, 1, 32'h12345678, 0, 1, 20'h00200, 32'hDEADBEEF, 0, 1, 32'h00B70113, 32'hCAFEF00D));
    vecs.push_back(mk(0, 20'h0, 0, 0, 20'h00200, 32'h0, 0, 32'h0,          0, 1, 20'h00200, 32'hDEADBEEF, 0, 0, 32'h00B70113, 32'hCAFEF00D));

    foreach (vecs[k]) begin
      i_req = vecs[k].i_req; i_addr = vecs[k].i_addr; d_req = vecs[k].d_req;
      d_we = vecs[k].d_we; d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
      mem_ready = vecs[k].ready; mem_rdata = vecs[k].rdata;
      tick();
      check($sformatf("v%0d mem_req", k), mem_req, vecs[k].x_mreq);
      check($sformatf("v%0d mem_we", k), mem_we, vecs[k].x_mwe);
      check($sformatf("v%0d mem_addr", k), mem_addr, vecs[k].x_maddr);
      check($sformatf("v%0d mem_wdata", k), mem_wdata, vecs[k].x_mwdata);
      check($sformatf("v%0d i_done", k), i_done, vecs[k].x_idone);
      check($sformatf("v%0d d_done", k), d_done, vecs[k].x_ddone);
      check($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].x_irdata);
      check($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].x_drdata);
      check($sformatf("v%0d timeout_err", k), timeout_err, 0);
    end

    // both requesters held: grants alternate D, I, D
    do_reset();
    i_req = 1; i_addr = 20'h000A0; d_req = 1; d_we = 0; d_addr = 20'h000D0; mem_ready = 0;
    for (int r = 0; r < 3; r++) begin
      exp_d = (r != 1);
      val = 32'h1000_0000 + 32'(r);
      tick();
      check($sformatf("arb%0d mem_req", r), mem_req, 1);
      check($sformatf("arb%0d mem_addr", r), mem_addr, exp_d ? 32'h000D0 : 32'h000A0);
      mem_ready = 1; mem_rdata = val;
      tick();
      mem_ready = 0;
      check($sformatf("arb%0d i_done", r), i_done, !exp_d);
      check($sformatf("arb%0d d_done", r), d_done, exp_d);
      check($sformatf("arb%0d rdata", r), exp_d ? d_rdata : i_rdata, val);
      tick();
      check($sformatf("arb%0d idle mem_req", r), mem_req, 0);
      check($sformatf("arb%0d idle done", r), {i_done, d_done}, 0);
    end

    // timeout on the TIMEOUT=4 instance, after one good read
    do_reset();
    i_req = 1; i_addr = 20'h00444;
    tick();
    mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_ready = 0;
    check("to first rdata", t_i_rdata, 32'h5A5A5A5A);
    tick();
    tick();
    check("to busy mem_req", t_mem_req, 1);
    tick(); tick(); tick();
    check("to b4 mem_req", t_mem_req, 1);
    check("to b4 no done", t_i_done, 0);
    tick();
    check("to done", t_i_done, 1);
    check("to rdata zero", t_i_rdata, 0);
    check("to err", t_timeout_err, 1);
    check("to long still busy", mem_req, 1);
    check("to long no err", timeout_err, 0);
    i_req = 0;
    for (int c = 0; c < 4; c++) tick();
    check("to err sticky", t_timeout_err, 1);
    check("to done cleared", t_i_done, 0);
    do_reset();
    check("to err cleared by reset", t_timeout_err, 0);

    // mem_ready on the timeout cycle completes normally
    i_req = 1; i_addr = 20'h00333;
    tick(); tick(); tick(); tick();
    mem_ready = 1; mem_rdata = 32'h00000777;
    tick();
    mem_ready = 0; i_req = 0;
    check("edge done", t_i_done, 1);
    check("edge rdata", t_i_rdata, 32'h00000777);
    check("edge no err", t_timeout_err, 0);
    check("edge long done", i_done, 1);
    tick();

    // reset during BUSY aborts; a late mem_ready is ignored
    do_reset();
    d_req = 1; d_we = 1; d_addr = 20'h00555; d_wdata = 32'h0000A5A5;
    tick();
    check("rb busy mem_req", mem_req, 1);
    check("rb busy mem_we", mem_we, 1);
    RST_N = 0;
    tick();
    check("rb mem_req", mem_req, 0);
    check("rb d_done", d_done, 0);
    check("rb mem_addr", mem_addr, 0);
    check("rb mem_we", mem_we, 0);
    check("rb mem_wdata", mem_wdata, 0);
    check("rb state", 32'(state_dbg), 32'(IDLE));
    RST_N = 1; d_req = 0; mem_ready = 1; mem_rdata = 32'h00000BAD;
    tick();
    mem_ready = 0;
    check("late mem_req", mem_req, 0);
    check("late d_done", d_done, 0);
    check("late d_rdata", d_rdata, 0);
    tick();
    check("late d_done2", d_done, 0);

    // requester drops mid-transaction; the transaction still completes
    d_req = 1; d_we = 0; d_addr = 20'h00666; d_wdata = 32'h0;
    tick();
    d_req = 0;
    tick();
    check("drop mem_req", mem_req, 1);
    mem_ready = 1; mem_rdata = 32'h00006666;
    tick();
    mem_ready = 0;
    check("drop d_done", d_done, 1);
    check("drop d_rdata", d_rdata, 32'h00006666);
    tick();
    check("drop idle", mem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max BUSY cycles waited for mem_ready before abort.
REQ-002 SHALL have port CLK  in  1  single clock; all logic on posedge CLK.
REQ-003 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_req  in  1  icache refill request, level, held until i_done.
REQ-005 SHALL have port i_addr  in  20  icache refill byte address.
REQ-006 SHALL have port i_done  out  1  one-cycle completion pulse; drives icache fetch.
REQ-007 SHALL have port i_rdata  out  32  refill word; valid while i_done=1.
REQ-008 SHALL have port d_req  in  1  dcache request, level, held until d_done.
REQ-009 SHALL have port d_we  in  1  dcache write (1) / read (0).
REQ-010 SHALL have port d_addr  in  20  dcache byte address.
REQ-011 SHALL have port d_wdata  in  32  dcache write data.
REQ-012 SHALL have port d_done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port d_rdata  out  32  read word; valid while d_done=1.
REQ-014 SHALL have port mem_req  out  1  memory request, high for the whole transaction.
REQ-015 SHALL have port mem_we  out  1  memory write enable.
REQ-016 SHALL have port mem_addr  out  20  memory address.
REQ-017 SHALL have port mem_wdata  out  32  memory write data.
REQ-018 SHALL have port mem_rdata  in  32  memory read data, valid with mem_ready.
REQ-019 SHALL have port mem_ready  in  1  memory completion, one cycle.
REQ-020 SHALL have port timeout_err  out  1  sticky timeout flag.

Function
REQ-021 SHALL implement states IDLE, BUSY, DONE; IDLE->BUSY on any req, BUSY->DONE on mem_ready or timeout, DONE->IDLE unconditionally.
REQ-022 SHALL in IDLE latch winner id, address, we (0 for icache) and wdata into registers driving mem_addr/mem_we/mem_wdata.
REQ-023 SHALL assert mem_req only in BUSY; mem_addr/mem_we/mem_wdata stable throughout BUSY.
REQ-024 SHALL arbitrate round-robin: single requester wins; both requesting -> requester not granted last wins; pointer updates on grant; after reset dcache wins a tie.
REQ-025 SHALL, on mem_ready in BUSY, capture mem_rdata into winner's rdata register and pulse winner's done in DONE (next cycle).
REQ-026 SHALL give latency: req seen in IDLE cycle N -> mem_req from N+1; mem_ready at cycle M -> done at M+1; earliest next grant at M+2.
REQ-027 SHALL hold i_rdata/d_rdata until that requester's next completion; writes leave d_rdata unchanged.
REQ-028 SHALL count BUSY cycles; counter width clog2(TIMEOUT+1), cleared on BUSY entry.
REQ-029 SHALL, when counter reaches TIMEOUT without mem_ready, go to DONE, pulse winner's done with rdata 0, set timeout_err.
REQ-030 SHALL give mem_ready priority over timeout in the same cycle (normal completion, no error).
REQ-031 SHALL ignore mem_ready outside BUSY.
REQ-032 SHALL complete an in-flight transaction even if its req deasserts; non-winner req stays pending.
REQ-033 SHALL never assert i_done and d_done in the same cycle.

Reset
REQ-034 SHALL, with RST_N=0 at a posedge, enter IDLE, clear mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata, counter, timeout_err to 0, pointer to "last=icache".
REQ-035 SHALL abort any in-flight transaction on reset with no done pulse; timeout_err clears only on reset.

Structure
REQ-036 SHALL place ADDR_W=20, DATA_W=32, state enum and requester-id enum in shared package mem_pkg.
REQ-037 SHALL be a single module with no sub-modules; arbitration and timeout inline.

Verification
REQ-038 SHALL test: i_req, i_addr=0x00104, mem_ready 3 cycles after mem_req with 0x00B70113 -> mem_we=0, i_done one cycle later, i_rdata=0x00B70113.
REQ-039 SHALL test: d_req write, d_addr=0x00200, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_done pulse, d_rdata unchanged.
REQ-040 SHALL test: i_req and d_req rise together, held, three times after reset -> grants D, I, D; done pulses never overlap.
REQ-041 SHALL test: TIMEOUT=4, no mem_ready -> done after 4 BUSY cycles with rdata 0, timeout_err=1 until RST_N low.
REQ-042 SHALL test: RST_N low during BUSY -> next cycle mem_req=0, no done, all outputs 0, and a late mem_ready is ignored.
REQ-043 SHALL test: mem_ready on the TIMEOUT cycle -> normal completion, timeout_err=0.
